pyc_rr_arbiter: RTL and testbench

PYC_RR_ARBITER -- requirements
Module: pyc_rr_arbiter

---
 rtl/pyc_rr_arbiter_pkg.sv | 10 +
 rtl/pyc_picker_onehot.sv | 21 ++
 rtl/pyc_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_pyc_rr_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pyc_rr_arbiter_pkg.sv
// Shared helpers for the round-robin arbiter slice.
// Holds no types: the arbiter keeps all of its parameters local.
package pyc_rr_arbiter_pkg;

  // Returns the search start that follows requester idx, wrapping from n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pyc_picker_onehot.sv
// One-hot payload selector: returns the in_data lane whose sel bit is set.
// Returns zero when sel is all-zero.
module pyc_picker_onehot #(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic [N-1:0]            sel,
  input  logic [N-1:0][WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]        out_data
);

  // AND-OR mux over the lanes; sel is one-hot, so at most one lane contributes.
  always_comb begin
    // NOTE: a default assignment ahead of the loop keeps every path assigned, so no latch is inferred.
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) out_data = out_data | in_data[i];
    end
  end

endmodule

// File: rtl/pyc_rr_arbiter.sv
// Round-robin N:1 arbiter with a one-deep registered output stage.
// Optional feature: define PYC_RR_ARB_LOCK_EN to add in_last and hold the grant
// on one requester until it sends its end-of-packet beat.
module pyc_rr_arbiter
  import pyc_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            in_valid,
  input  logic [N-1:0][WIDTH-1:0] in_data,
`ifdef PYC_RR_ARB_LOCK_EN
  input  logic [N-1:0]            in_last,
`endif
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [N-1:0]            out_grant,
  input  logic                    out_ready
);

  localparam int PW = $clog2(N);

  if (N < 2) begin : g_n_check
    $error("pyc_rr_arbiter: N must be at least 2");
  end

  logic [PW-1:0]    ptr;
  logic [N-1:0]     scan_grant;
  logic [PW-1:0]    scan_idx;
  logic [N-1:0]     grant;
  logic [PW-1:0]    grant_idx;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] pick_data;

  // Rotating search from ptr; descending loop so the nearest valid requester is written last and wins.
  always_comb begin
    scan_grant = '0;
    scan_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (in_valid[(int'(ptr) + k) % N]) begin
        scan_grant = '0;
        scan_grant[(int'(ptr) + k) % N] = 1'b1;
        scan_idx   = PW'((int'(ptr) + k) % N);
      end
    end
  end

`ifdef PYC_RR_ARB_LOCK_EN
  logic          lock;
  logic [PW-1:0] owner_idx;

  // The packet owner is the last source captured, which the registered out_grant already records.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (out_grant[i]) owner_idx = PW'(i);
    end
  end

  // While a packet is open only its owner may be granted; otherwise use the rotating search.
  always_comb begin
    if (lock) begin
      grant     = in_valid & out_grant;
      grant_idx = owner_idx;
    end else begin
      grant     = scan_grant;
      grant_idx = scan_idx;
    end
  end

  // Lock opens on a non-last beat and closes on the owner's last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lock <= 1'b0;
    else if (xfer) lock <= !in_last[grant_idx];
  end
`else
  assign grant     = scan_grant;
  assign grant_idx = scan_idx;
`endif

  // The output register may load when it is empty or being drained this cycle.
  assign load     = !out_valid || out_ready;
  assign in_ready = grant & {N{load}};
  assign xfer     = load && (|grant);

  pyc_picker_onehot #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_picker (
    .sel      (grant),
    .in_data  (in_data),
    .out_data (pick_data)
  );

  // Search pointer moves just past the served requester; with locking, only on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers use non-blocking assignments so every flop samples the same pre-edge values.
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
`ifdef PYC_RR_ARB_LOCK_EN
      if (in_last[grant_idx]) ptr <= PW'(rr_next(int'(grant_idx), N));
`else
      ptr <= PW'(rr_next(int'(grant_idx), N));
`endif
    end
  end

  // Output stage: capture on a transfer, empty on a load without one, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= pick_data;
        out_grant <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pyc_rr_arbiter.sv
// Self-checking bench for pyc_rr_arbiter: an N=4 and an N=3 instance run side by side
// against a behavioural model of the round-robin rules. Define PYC_RR_ARB_LOCK_EN for the lock build.
module tb_pyc_rr_arbiter;

`ifdef PYC_RR_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [3:0]      v4, rdy4, og4, last4;
  logic [3:0][7:0] d4;
  logic            or4, ov4;
  logic [7:0]      od4;
  logic [2:0]      v3, rdy3, og3, last3;
  logic [2:0][7:0] d3;
  logic            or3, ov3;
  logic [7:0]      od3;

  int vectors = 0;
  int fails   = 0;

  pyc_rr_arbiter #(.WIDTH(8), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_data(d4),
`ifdef PYC_RR_ARB_LOCK_EN
    .in_last(last4),
`endif
    .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_grant(og4), .out_ready(or4)
  );

  pyc_rr_arbiter #(.WIDTH(8), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3),
`ifdef PYC_RR_ARB_LOCK_EN
    .in_last(last3),
`endif
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_grant(og3), .out_ready(or3)
  );

  // Behavioural state: next search start, output register contents, open-packet owner.
  typedef struct {
    int         ptr;
    bit         ov;
    logic [7:0] od;
    logic [3:0] og;
    bit         lock;
    int         owner;
  } model_t;

  model_t m4, m3;

  function automatic model_t model_reset();
    model_t m;
    m.ptr = 0; m.ov = 1'b0; m.od = 8'h00; m.og = 4'h0; m.lock = 1'b0; m.owner = 0;
    return m;
  endfunction

  // Requester the rules would serve now, or -1 when nobody is eligible.
  function automatic int pick(model_t m, int n, logic [3:0] v);
    if (m.lock) return v[m.owner] ? m.owner : -1;
    for (int k = 0; k < n; k++) begin
      if (v[(m.ptr + k) % n]) return (m.ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(model_t m, int n, logic [3:0] v, logic ordy);
    int idx;
    idx = pick(m, n, v);
    if (idx < 0 || !(!m.ov || ordy)) return 4'h0;
    return 4'(1 << idx);
  endfunction

  function automatic model_t advance(model_t m, int n, logic [3:0] v, logic [3:0][7:0] d,
                                     logic ordy, logic [3:0] last);
    int idx;
    if (m.ov && !ordy) return m;
    idx = pick(m, n, v);
    if (idx < 0) begin
      m.ov = 1'b0;
    end else begin
      m.ov = 1'b1;
      m.od = d[idx];
      m.og = 4'(1 << idx);
      if (LOCK && !last[idx]) begin
        m.lock = 1'b1; m.owner = idx;
      end else begin
        m.lock = 1'b0; m.ptr = (idx + 1) % n;
      end
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready on settled inputs, step both models at the edge, check registers after it.
  task automatic cycle();
    #1;
    check("in_ready4", 32'(rdy4), 32'(exp_ready(m4, 4, v4, or4)));
    check("in_ready3", 32'(rdy3), 32'(exp_ready(m3, 3, {1'b0, v3}, or3)));
    @(posedge clk);
    m4 = advance(m4, 4, v4, d4, or4, last4);
    m3 = advance(m3, 3, {1'b0, v3}, {8'h00, d3}, or3, {1'b1, last3});
    #1;
    check("out_valid4", 32'(ov4), 32'(m4.ov));
    check("out_data4",  32'(od4), 32'(m4.od));
    check("out_grant4", 32'(og4), 32'(m4.og));
    check("out_valid3", 32'(ov3), 32'(m3.ov));
    check("out_data3",  32'(od3), 32'(m3.od));
    check("out_grant3", 32'(og3), 32'(m3.og));
  endtask

  task automatic idle_inputs();
    v4 = '0; d4 = '0; or4 = 1'b1; last4 = '1;
    v3 = '0; d3 = '0; or3 = 1'b1; last3 = '1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    m4 = model_reset();
    m3 = model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [3:0] held_g;
  logic [7:0] held_d;

  initial begin
    apply_reset();
    check("rst_out_valid4", 32'(ov4), 32'h0);
    check("rst_out_data4",  32'(od4), 32'h0);
    check("rst_out_grant4", 32'(og4), 32'h0);
    check("rst_out_valid3", 32'(ov3), 32'h0);

    // All four requesters valid with a free sink: strict rotation, one beat per cycle.
    v4 = 4'hF;
    d4 = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("rot_grant", 32'(og4), 32'(1 << (k % 4)));
      check("rot_data",  32'(od4), 32'(8'h11 * ((k % 4) + 1)));
    end

    // Stall the sink for three cycles: output frozen, nothing accepted.
    or4 = 1'b0;
    held_g = og4;
    held_d = od4;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_grant", 32'(og4), 32'(held_g));
      check("stall_data",  32'(od4), 32'(held_d));
      check("stall_ready", 32'(rdy4), 32'h0);
    end
    // Release: requester 1 is next and loads on the draining edge.
    or4 = 1'b1;
    cycle();
    check("release_grant", 32'(og4), 32'h2);

    // Five idle cycles: output empties and the search start is left where it was.
    v4 = 4'h0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("idle_valid", 32'(ov4), 32'h0);
    end
    v4 = 4'hF;
    cycle();
    check("idle_ptr_kept", 32'(og4), 32'h4);

    // Reset during a stall clears the output without waiting for a clock edge.
    or4 = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(ov4), 32'h0);
    check("async_rst_grant", 32'(og4), 32'h0);
    m4 = model_reset();
    m3 = model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    or4 = 1'b1;
    cycle();
    check("post_rst_grant", 32'(og4), 32'h1);
    v4 = 4'h0;

    // N=3: only requester 2 valid from ptr 0, then the pointer wraps back to requester 0.
    v3 = 3'b100;
    d3 = {8'hC2, 8'hB1, 8'hA0};
    cycle();
    check("n3_grant2", 32'(og3), 32'h4);
    v3 = 3'b011;
    cycle();
    check("n3_wrap_grant0", 32'(og3), 32'h1);
    v3 = 3'b000;
    cycle();

`ifdef PYC_RR_ARB_LOCK_EN
    // Requester 0 sends a three-beat packet while requester 1 waits.
    apply_reset();
    v4 = 4'b0011;
    d4 = {8'h00, 8'h00, 8'hBB, 8'hAA};
    for (int k = 0; k < 4; k++) begin
      last4 = {3'b111, (k == 2)};
      cycle();
      check("lock_grant", 32'(og4), (k < 3) ? 32'h1 : 32'h2);
    end
`endif

    // Randomised traffic on both instances against the model.
    for (int k = 0; k < 300; k++) begin
      v4 = 4'($urandom);
      d4 = $urandom;
      or4 = ($urandom_range(3) != 0);
      last4 = LOCK ? 4'($urandom | $urandom) : 4'hF;
      v3 = 3'($urandom);
      d3 = 24'($urandom);
      or3 = ($urandom_range(3) != 0);
      last3 = LOCK ? 3'($urandom | $urandom) : 3'h7;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
